// File: rtl/digest_hex_tx.sv
// Prints a digest word as lowercase ASCII hex over an AXI-Stream byte port,
// most-significant nibble first, optionally followed by CR LF.
module digest_hex_tx #(
  parameter int DIGEST_WIDTH = 256,
  parameter bit APPEND_CRLF  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIGEST_WIDTH-1:0] s_digest,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy
);

  localparam int NCHAR = DIGEST_WIDTH / 4;
  localparam int CW    = $clog2(NCHAR);
  localparam logic [CW-1:0] LAST = CW'(NCHAR - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEX  = 2'd1;
  localparam logic [1:0] ST_CR   = 2'd2;
  localparam logic [1:0] ST_LF   = 2'd3;

  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DIGEST_WIDTH-1:0] dig_q, dig_d;
  logic [7:0]              tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    xfer, accept;

  assign xfer   = tvalid_q & m_axis_tready;
  assign accept = s_valid & ready_q;

  // dig_q always holds the not-yet-printed nibbles left-aligned; the byte on
  // the bus is already encoded, so the next char is taken from the top nibble.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_HEX;
          cnt_d    = '0;
          dig_d    = s_digest << 4;
          tdata_d  = hex_char(s_digest[DIGEST_WIDTH-1 -: 4]);
          tvalid_d = 1'b1;
        end
      end
      ST_HEX: begin
        if (xfer) begin
          if (cnt_q == LAST) begin
            if (APPEND_CRLF) begin
              state_d = ST_CR;
              tdata_d = CH_CR;
            end else begin
              state_d  = ST_IDLE;
              tvalid_d = 1'b0;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            dig_d   = dig_q << 4;
            tdata_d = hex_char(dig_q[DIGEST_WIDTH-1 -: 4]);
          end
        end
      end
      ST_CR: begin
        if (xfer) begin
          state_d = ST_LF;
          tdata_d = CH_LF;
        end
      end
      ST_LF: begin
        if (xfer) begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dig_q    <= '0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign s_ready       = ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_digest_hex_tx.sv
// Directed bench for digest_hex_tx: 256-bit with CRLF and 32-bit without.
module tb_digest_hex_tx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [255:0] a_digest = '0;
  logic         a_valid = 1'b0;
  logic         a_ready;
  logic [7:0]   a_tdata;
  logic         a_tvalid;
  logic         a_tready = 1'b1;
  logic         a_busy;

  logic [31:0]  b_digest = '0;
  logic         b_valid = 1'b0;
  logic         b_ready;
  logic [7:0]   b_tdata;
  logic         b_tvalid;
  logic         b_tready = 1'b1;
  logic         b_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digest_hex_tx #(.DIGEST_WIDTH(256), .APPEND_CRLF(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .s_digest(a_digest), .s_valid(a_valid), .s_ready(a_ready),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready), .busy(a_busy));

  digest_hex_tx #(.DIGEST_WIDTH(32), .APPEND_CRLF(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .s_digest(b_digest), .s_valid(b_valid), .s_ready(b_ready),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready), .busy(b_busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [255:0] d);
    chk("s_ready_pre", a_ready, 1);
    a_digest = d;
    a_valid  = 1'b1;
    @(negedge clk);
    a_valid  = 1'b0;
    chk("busy_msg", a_busy, 1);
  endtask

  // Expected bytes are pat repeated reps times, then CR LF if crlf.
  task automatic stream(input string pat, input int reps, input int crlf, input int duty,
                        input int limit, input int nobubble, output int cycles);
    logic [7:0] q[$];
    int got = 0;
    int cyc = 0;
    int lim;
    logic pend = 1'b0;
    logic [7:0] pdat = 8'h00;
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < pat.len(); i++) q.push_back(pat.getc(i));
    if (crlf != 0) begin
      q.push_back(8'h0d);
      q.push_back(8'h0a);
    end
    lim = (limit == 0 || limit > q.size()) ? q.size() : limit;
    while (got < lim && cyc < 4000) begin
      a_tready = ($urandom_range(99) < duty);
      if (pend) begin
        chk("hold_vld", a_tvalid, 1);
        chk("hold_dat", a_tdata, pdat);
      end
      if (nobubble != 0) chk("nobubble", a_tvalid, 1);
      if (a_tvalid && a_tready) begin
        chk("byte", a_tdata, q[got]);
        got++;
      end
      pend = a_tvalid && !a_tready;
      pdat = a_tdata;
      cyc++;
      @(negedge clk);
    end
    if (got < lim) chk("timeout", got, lim);
    a_tready = 1'b1;
    cycles = cyc;
  endtask

  task automatic end_check();
    chk("end_tvalid", a_tvalid, 0);
    chk("end_ready", a_ready, 1);
    chk("end_busy", a_busy, 0);
  endtask

  initial begin
    int cyc;
    string bs;
    logic [255:0] d_ramp;
    logic [255:0] d_rev;
    d_ramp = {4{64'h0123456789abcdef}};
    d_rev  = {4{64'hfedcba9876543210}};
    bs = "deadbeef";

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", a_ready, 0);
    chk("rst_tvalid", a_tvalid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_tdata", a_tdata, 0);
    chk("rst_b_ready", b_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", a_ready, 1);

    // 66 bytes back-to-back, idle on cycle 67
    send(d_ramp);
    stream("0123456789abcdef", 4, 1, 100, 0, 1, cyc);
    chk("cycles66", cyc, 66);
    end_check();

    send('0);
    stream("0000000000000000", 4, 1, 100, 0, 1, cyc);
    end_check();
    send({256{1'b1}});
    stream("ffffffffffffffff", 4, 1, 100, 0, 1, cyc);
    end_check();

    // throttled sink
    send(d_ramp);
    stream("0123456789abcdef", 4, 1, 30, 0, 0, cyc);
    end_check();

    // reset after the 10th byte
    send(d_ramp);
    stream("0123456789abcdef", 4, 1, 100, 10, 1, cyc);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", a_tvalid, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_ready", a_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_up", a_ready, 1);
    send('0);
    stream("0000000000000000", 4, 1, 100, 0, 1, cyc);
    end_check();

    // s_valid held with a second digest queued; its arrival must not disturb message 1
    a_digest = d_rev;
    a_valid  = 1'b1;
    @(negedge clk);
    a_digest = d_ramp;
    stream("fedcba9876543210", 4, 1, 100, 0, 1, cyc);
    chk("b2b_idle_tvalid", a_tvalid, 0);
    chk("b2b_idle_ready", a_ready, 1);
    @(negedge clk);
    a_valid  = 1'b0;
    a_digest = '0;
    chk("b2b_second_start", a_tvalid, 1);
    stream("0123456789abcdef", 4, 1, 100, 0, 1, cyc);
    end_check();

    // 32-bit, no CRLF
    chk("b_ready_pre", b_ready, 1);
    b_digest = 32'hdeadbeef;
    b_valid  = 1'b1;
    @(negedge clk);
    b_valid  = 1'b0;
    b_digest = 32'h12345678;
    for (int i = 0; i < 8; i++) begin
      chk("b_tvalid", b_tvalid, 1);
      chk("b_byte", b_tdata, bs.getc(i));
      @(negedge clk);
    end
    chk("b_end_tvalid", b_tvalid, 0);
    chk("b_end_ready", b_ready, 1);
    chk("b_end_busy", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digest_hex_tx.md
DIGEST_HEX_TX -- requirements
Module: digest_hex_tx

Interface
REQ-001 SHALL provide parameter DIGEST_WIDTH, default 256, digest width in bits; legal values are multiples of 4 from 8 to 512.
REQ-002 SHALL provide parameter APPEND_CRLF, default 1; when 1, CR and LF follow the hex characters.
REQ-003 SHALL provide port clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL provide port s_digest  input  DIGEST_WIDTH  digest word to be printed.
REQ-006 SHALL provide port s_valid  input  1  digest valid.
REQ-007 SHALL provide port s_ready  output  1  block can accept a digest.
REQ-008 SHALL provide port m_axis_tdata  output  8  ASCII byte toward the UART transmitter.
REQ-009 SHALL provide port m_axis_tvalid  output  1  byte valid.
REQ-010 SHALL provide port m_axis_tready  input  1  downstream accepts the byte.
REQ-011 SHALL provide port busy  output  1  high whenever the block is not in IDLE.

Function
REQ-012 SHALL drive all outputs from registers, with no combinational input-to-output path.
REQ-013 SHALL implement the states IDLE, HEX, CR and LF.
REQ-014 SHALL hold s_ready=1 only in IDLE.
REQ-015 SHALL latch s_digest on a cycle where s_valid and s_ready are both high.
REQ-016 SHALL, on that latch, enter HEX in the same edge, so m_axis_tvalid=1 with the first character on the next cycle (latency 1).
REQ-017 SHALL emit DIGEST_WIDTH/4 characters, most-significant nibble first.
REQ-018 SHALL encode nibble values 0-9 as 0x30-0x39 and values 10-15 as lowercase 0x61-0x66.
REQ-019 SHALL hold m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 SHALL keep m_axis_tvalid high until the byte is transferred; m_axis_tvalid SHALL never drop while a byte is pending.
REQ-021 SHALL, when m_axis_tready is continuously high, transfer one byte per cycle with no bubbles, including the HEX->CR and CR->LF boundaries.
REQ-022 SHALL use a nibble counter of width ceil(log2(DIGEST_WIDTH/4)); it SHALL reset to 0 on each digest latch and increment per HEX transfer, with no wrap inside a message.
REQ-023 SHALL, on the last HEX transfer, go to CR (0x0D) if APPEND_CRLF=1, otherwise to IDLE.
REQ-024 SHALL, on the CR transfer, go to LF (0x0A).
REQ-025 SHALL, on the LF transfer, go to IDLE.
REQ-026 SHALL show m_axis_tvalid=0 and s_ready=1 in the cycle after the final transfer.
REQ-027 SHALL ignore s_valid and s_digest outside IDLE; later changes to s_digest SHALL NOT affect the current message.
REQ-028 SHALL allow back-to-back digests with at most one idle cycle (the IDLE cycle) between the LF of one message and the first character of the next.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, enter IDLE, clear the nibble counter, and set m_axis_tvalid=0, busy=0, s_ready=0 and m_axis_tdata=0x00.
REQ-030 SHALL raise s_ready to 1 on the first edge with rst_n=1.
REQ-031 SHALL, on reset mid-message, abandon the message with no resumption; m_axis_tvalid SHALL be 0 from the next cycle.

Verification
REQ-032 SHALL cover: DIGEST_WIDTH=256, digest 0x0123456789abcdef repeated 4x, tready=1 -> "0123456789abcdef"x4, then 0x0D, 0x0A in 66 consecutive cycles; s_ready=1 on cycle 67.
REQ-033 SHALL cover: digest all-zero and all-ones -> 64x0x30 and 64x0x66 respectively, each followed by 0x0D 0x0A.
REQ-034 SHALL cover: random tready with about 30% duty -> identical byte sequence to REQ-032, with tdata stable and tvalid never dropping while pending.
REQ-035 SHALL cover: rst_n=0 for 1 cycle after the 10th byte -> tvalid=0 next cycle, busy=0, and a new digest is accepted after reset.
REQ-036 SHALL cover: s_valid held high with two digests queued -> second message starts exactly 1 cycle after the first LF transfer, and s_digest changes mid-message are ignored.
REQ-037 SHALL cover: APPEND_CRLF=0, DIGEST_WIDTH=32, digest 0xdeadbeef -> bytes "deadbeef" only, then IDLE.
